// File: rtl/dual_port_block_ram.sv
// True dual-port synchronous RAM: byte-lane writes, 1- or 2-cycle read latency,
// selectable same-port read-during-write behaviour, optional zero fill after reset.
module dual_port_block_ram #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int READ_LATENCY  = 1,
    parameter int RW_MODE       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ready,
    input  logic                      a_en,
    input  logic                      a_we,
    input  logic [DATA_WIDTH/8-1:0]   a_be,
    input  logic [ADDR_WIDTH-1:0]     a_addr,
    input  logic [DATA_WIDTH-1:0]     a_wdata,
    output logic [DATA_WIDTH-1:0]     a_rdata,
    output logic                      a_rvalid,
    input  logic                      b_en,
    input  logic                      b_we,
    input  logic [DATA_WIDTH/8-1:0]   b_be,
    input  logic [ADDR_WIDTH-1:0]     b_addr,
    input  logic [DATA_WIDTH-1:0]     b_wdata,
    output logic [DATA_WIDTH-1:0]     b_rdata,
    output logic                      b_rvalid,
    output logic                      collision
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] init_addr_reg;
    logic                  ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RESET;
            init_addr_reg <= '0;
            ready_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    init_addr_reg <= '0;
                    if (INIT_ON_RESET != 0) begin
                        state_reg <= ST_INIT;
                    end else begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                ST_INIT: begin
                    init_addr_reg <= init_addr_reg + ADDR_WIDTH'(1);
                    if (init_addr_reg == {ADDR_WIDTH{1'b1}}) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                default: ready_reg <= 1'b1;
            endcase
        end
    end

    assign ready = ready_reg;

    // The zero fill borrows port A's write path while user accesses are blocked.
    logic                  init_active;
    logic                  a_acc;
    logic                  b_acc;
    logic                  a_rd;
    logic                  b_rd;
    logic [ADDR_WIDTH-1:0] a_mem_addr;

    assign init_active = (state_reg == ST_INIT) && !rst;
    assign a_acc       = ready_reg && a_en && !rst;
    assign b_acc       = ready_reg && b_en && !rst;
    assign a_rd        = a_acc && !(a_we && (RW_MODE == 2));
    assign b_rd        = b_acc && !(b_we && (RW_MODE == 2));
    assign a_mem_addr  = init_active ? init_addr_reg : a_addr;

    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] a_q_reg;
            logic [7:0] b_q_reg;
            logic       a_lane_we;
            logic       b_lane_we;
            logic [7:0] a_lane_wdata;

            assign a_lane_we    = init_active || (a_acc && a_we && a_be[gi]);
            assign b_lane_we    = b_acc && b_we && b_be[gi];
            assign a_lane_wdata = init_active ? 8'h00 : a_wdata[gi*8 +: 8];

            // Port B is written first so port A wins any lane both ports write.
            always_ff @(posedge clk) begin
                if (b_lane_we) begin
                    mem[b_addr] <= b_wdata[gi*8 +: 8];
                end
                if (a_lane_we) begin
                    mem[a_mem_addr] <= a_lane_wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q_reg <= 8'h00;
                    b_q_reg <= 8'h00;
                end else begin
                    if (a_rd) begin
                        a_q_reg <= ((RW_MODE == 1) && a_lane_we) ? a_wdata[gi*8 +: 8] : mem[a_addr];
                    end
                    if (b_rd) begin
                        b_q_reg <= ((RW_MODE == 1) && b_lane_we) ? b_wdata[gi*8 +: 8] : mem[b_addr];
                    end
                end
            end

            assign a_q[gi*8 +: 8] = a_q_reg;
            assign b_q[gi*8 +: 8] = b_q_reg;
        end
    endgenerate

    logic a_v1_reg;
    logic b_v1_reg;
    logic collision_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_v1_reg      <= 1'b0;
            b_v1_reg      <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            a_v1_reg      <= a_rd;
            b_v1_reg      <= b_rd;
            collision_reg <= a_acc && b_acc && a_we && b_we && (a_addr == b_addr);
        end
    end

    assign collision = collision_reg;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  a_v2_reg;
            logic                  b_v2_reg;
            logic [DATA_WIDTH-1:0] a_rdata_reg;
            logic [DATA_WIDTH-1:0] b_rdata_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_v2_reg    <= 1'b0;
                    b_v2_reg    <= 1'b0;
                    a_rdata_reg <= '0;
                    b_rdata_reg <= '0;
                end else begin
                    a_v2_reg <= a_v1_reg;
                    b_v2_reg <= b_v1_reg;
                    if (a_v1_reg) begin
                        a_rdata_reg <= a_q;
                    end
                    if (b_v1_reg) begin
                        b_rdata_reg <= b_q;
                    end
                end
            end

            assign a_rvalid = a_v2_reg;
            assign b_rvalid = b_v2_reg;
            assign a_rdata  = a_rdata_reg;
            assign b_rdata  = b_rdata_reg;
        end else begin : g_lat1
            assign a_rvalid = a_v1_reg;
            assign b_rvalid = b_v1_reg;
            assign a_rdata  = a_q;
            assign b_rdata  = b_q;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_block_ram.sv
// Bench for dual_port_block_ram: three instances (latency 2 read-first, latency 1
// write-first, latency 1 no-change) share stimulus and are checked against a word-level model.
module tb_dual_port_block_ram;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_en, a_we, b_en, b_we;
    logic [1:0]  a_be, b_be;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;

    wire [NDUT-1:0]             ready_w;
    wire [NDUT-1:0]             coll_w;
    wire [NDUT-1:0][1:0]        rv_w;
    wire [NDUT-1:0][1:0][15:0]  rd_w;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            dual_port_block_ram #(
                .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(gi == 0 ? 2 : 1),
                .RW_MODE(gi), .INIT_ON_RESET(1)
            ) dut (
                .clk(clk), .rst(rst), .ready(ready_w[gi]),
                .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
                .a_rdata(rd_w[gi][0]), .a_rvalid(rv_w[gi][0]),
                .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
                .b_rdata(rd_w[gi][1]), .b_rvalid(rv_w[gi][1]),
                .collision(coll_w[gi])
            );
        end
    endgenerate

    // Word-level reference model
    logic [15:0] ref_mem [DEPTH];
    bit          ready_m;
    int          rel_cnt;
    int          cyc;
    bit          pend_v [NDUT][2][4];
    logic [15:0] pend_d [NDUT][2][4];
    bit          exp_v  [NDUT][2];
    logic [15:0] exp_d  [NDUT][2];
    bit          exp_coll;
    int          n_cmp;
    int          n_fail;

    function automatic int lat_of(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] wd, logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    task automatic tick();
        bit          acc [2];
        bit          we  [2];
        logic [15:0] old [2];
        logic [15:0] wd  [2];
        logic [1:0]  be  [2];
        logic [7:0]  ad  [2];
        int          slot;
        @(posedge clk);
        cyc++;
        we[0] = a_we; wd[0] = a_wdata; be[0] = a_be; ad[0] = a_addr;
        we[1] = b_we; wd[1] = b_wdata; be[1] = b_be; ad[1] = b_addr;
        if (rst) begin
            rel_cnt  = 0;
            ready_m  = 1'b0;
            exp_coll = 1'b0;
            for (int d = 0; d < NDUT; d++)
                for (int p = 0; p < 2; p++) begin
                    exp_d[d][p] = 16'h0000;
                    for (int s = 0; s < 4; s++) pend_v[d][p][s] = 1'b0;
                end
        end else begin
            acc[0] = ready_m && a_en;
            acc[1] = ready_m && b_en;
            for (int p = 0; p < 2; p++) old[p] = ref_mem[ad[p]];
            for (int d = 0; d < NDUT; d++)
                for (int p = 0; p < 2; p++)
                    if (acc[p]) begin
                        slot = (cyc + lat_of(d) - 1) % 4;
                        if (!we[p] || d == 0) begin
                            pend_v[d][p][slot] = 1'b1;
                            pend_d[d][p][slot] = old[p];
                        end else if (d == 1) begin
                            pend_v[d][p][slot] = 1'b1;
                            pend_d[d][p][slot] = merge(old[p], wd[p], be[p]);
                        end
                    end
            exp_coll = acc[0] && acc[1] && we[0] && we[1] && (ad[0] == ad[1]);
            if (acc[1] && we[1]) ref_mem[ad[1]] = merge(ref_mem[ad[1]], wd[1], be[1]);
            if (acc[0] && we[0]) ref_mem[ad[0]] = merge(ref_mem[ad[0]], wd[0], be[0]);
            rel_cnt++;
            if (!ready_m && rel_cnt >= DEPTH + 1) begin
                ready_m = 1'b1;
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
            end
        end
        for (int d = 0; d < NDUT; d++)
            for (int p = 0; p < 2; p++) begin
                slot = cyc % 4;
                exp_v[d][p] = pend_v[d][p][slot];
                if (exp_v[d][p]) exp_d[d][p] = pend_d[d][p][slot];
                pend_v[d][p][slot] = 1'b0;
            end
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = 8'h00; a_wdata = 16'h0000;
        b_en = 1'b0; b_we = 1'b0; b_be = 2'b00; b_addr = 8'h00; b_wdata = 16'h0000;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        $display("txn reset: rst held 2 cycles");
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (ready_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready dut%0d got %b expected 0", d, ready_w[d]); end
            n_cmp++;
            if (coll_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset_collision dut%0d got %b expected 0", d, coll_w[d]); end
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (rv_w[d][p] !== 1'b0 || rd_w[d][p] !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL reset_read dut%0d port%0d got rvalid=%b rdata=%h expected 0/0000", d, p, rv_w[d][p], rd_w[d][p]);
                end
            end
        end
    endtask

    task automatic test_init();
        int rise = -1;
        bit got  = 1'b0;
        rst = 1'b0;
        a_en = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        b_en = 1'b1; b_we = 1'b1; b_addr = 8'h10; b_be = 2'b11; b_wdata = 16'($urandom);
        for (int c = 1; c <= 262; c++) begin
            tick();
            if (rise < 0 && ready_w[0] === 1'b1) rise = c;
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (ready_w[d] !== ready_m) begin n_fail++; $display("FAIL init_ready c=%0d dut%0d got %b expected %b", c, d, ready_w[d], ready_m); end
                for (int p = 0; p < 2; p++) begin
                    n_cmp++;
                    if (rv_w[d][p] !== exp_v[d][p] || rd_w[d][p] !== exp_d[d][p]) begin
                        n_fail++;
                        $display("FAIL init_read c=%0d dut%0d port%0d got %b/%h expected %b/%h", c, d, p, rv_w[d][p], rd_w[d][p], exp_v[d][p], exp_d[d][p]);
                    end
                end
            end
            if (!got && rv_w[1][0] === 1'b1) begin
                got = 1'b1;
                n_cmp++;
                if (rd_w[1][0] !== 16'h0000) begin n_fail++; $display("FAIL init_first_read got %h expected 0000", rd_w[1][0]); end
            end
        end
        $display("txn init: ready rose after cycle %0d", rise);
        n_cmp++;
        if (rise != 257) begin n_fail++; $display("FAIL init_ready_cycle got %0d expected 257", rise); end
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL init_first_read got no rvalid expected one"); end
        idle();
    endtask

    task automatic test_cross_port();
        a_en = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = 8'h05; a_wdata = 16'hBEEF;
        $display("txn cross_port: A write addr=05 data=beef be=11");
        tick();
        idle();
        b_en = 1'b1; b_addr = 8'h05;
        $display("txn cross_port: B read addr=05");
        tick();
        idle();
        n_cmp++;
        if (rv_w[0][1] !== 1'b0) begin n_fail++; $display("FAIL cross_early_rvalid got %b expected 0", rv_w[0][1]); end
        n_cmp++;
        if (rv_w[1][1] !== 1'b1 || rd_w[1][1] !== 16'hBEEF) begin n_fail++; $display("FAIL cross_lat1 got %b/%h expected 1/beef", rv_w[1][1], rd_w[1][1]); end
        tick();
        n_cmp++;
        if (rv_w[0][1] !== 1'b1 || rd_w[0][1] !== 16'hBEEF) begin n_fail++; $display("FAIL cross_lat2 got %b/%h expected 1/beef", rv_w[0][1], rd_w[0][1]); end
        tick();
        n_cmp++;
        if (rv_w[0][1] !== 1'b0 || rd_w[0][1] !== 16'hBEEF) begin n_fail++; $display("FAIL cross_hold got %b/%h expected 0/beef", rv_w[0][1], rd_w[0][1]); end
    endtask

    task automatic test_rw_mode();
        a_en = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = 8'h07; a_wdata = 16'h1234;
        $display("txn rw_mode: A write addr=07 data=1234 be=11");
        tick();
        a_wdata = 16'hABCD; a_be = 2'b10;
        $display("txn rw_mode: A write addr=07 data=abcd be=10");
        tick();
        idle();
        n_cmp++;
        if (rv_w[1][0] !== 1'b1 || rd_w[1][0] !== 16'hAB34) begin n_fail++; $display("FAIL rw_write_first got %b/%h expected 1/ab34", rv_w[1][0], rd_w[1][0]); end
        n_cmp++;
        if (rv_w[2][0] !== 1'b0 || rd_w[2][0] !== exp_d[2][0]) begin n_fail++; $display("FAIL rw_no_change got %b/%h expected 0/%h", rv_w[2][0], rd_w[2][0], exp_d[2][0]); end
        n_cmp++;
        if (rv_w[0][0] !== 1'b1 || rd_w[0][0] !== 16'h0000) begin n_fail++; $display("FAIL rw_read_first_1 got %b/%h expected 1/0000", rv_w[0][0], rd_w[0][0]); end
        tick();
        n_cmp++;
        if (rv_w[0][0] !== 1'b1 || rd_w[0][0] !== 16'h1234) begin n_fail++; $display("FAIL rw_read_first_2 got %b/%h expected 1/1234", rv_w[0][0], rd_w[0][0]); end
        a_en = 1'b1; a_addr = 8'h07;
        $display("txn rw_mode: A read addr=07");
        tick();
        idle();
        n_cmp++;
        if (rv_w[2][0] !== 1'b1 || rd_w[2][0] !== 16'hAB34) begin n_fail++; $display("FAIL rw_readback_lat1 got %b/%h expected 1/ab34", rv_w[2][0], rd_w[2][0]); end
        tick();
        n_cmp++;
        if (rd_w[0][0] !== 16'hAB34) begin n_fail++; $display("FAIL rw_readback_lat2 got %h expected ab34", rd_w[0][0]); end
    endtask

    task automatic test_collision();
        a_en = 1'b1; a_we = 1'b1; a_be = 2'b01; a_addr = 8'h20; a_wdata = 16'h1111;
        b_en = 1'b1; b_we = 1'b1; b_be = 2'b11; b_addr = 8'h20; b_wdata = 16'h2222;
        $display("txn collision: A write 20=1111 be=01, B write 20=2222 be=11");
        tick();
        idle();
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (coll_w[d] !== 1'b1) begin n_fail++; $display("FAIL coll_pulse dut%0d got %b expected 1", d, coll_w[d]); end
        end
        tick();
        n_cmp++;
        if (coll_w[0] !== 1'b0) begin n_fail++; $display("FAIL coll_one_cycle got %b expected 0", coll_w[0]); end
        a_en = 1'b1; a_addr = 8'h20;
        $display("txn collision: A read addr=20");
        tick();
        n_cmp++;
        if (rd_w[1][0] !== 16'h2211) begin n_fail++; $display("FAIL coll_merge got %h expected 2211", rd_w[1][0]); end
        b_en = 1'b1; b_we = 1'b1; b_be = 2'b11; b_addr = 8'h20; b_wdata = 16'h3333;
        $display("txn collision: A read 20, B write 20=3333");
        tick();
        idle();
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (coll_w[d] !== 1'b0) begin n_fail++; $display("FAIL coll_rw_none dut%0d got %b expected 0", d, coll_w[d]); end
        end
        n_cmp++;
        if (rv_w[1][0] !== 1'b1 || rd_w[1][0] !== 16'h2211) begin n_fail++; $display("FAIL coll_rw_old got %b/%h expected 1/2211", rv_w[1][0], rd_w[1][0]); end
        n_cmp++;
        if (rv_w[1][1] !== 1'b1 || rd_w[1][1] !== 16'h3333) begin n_fail++; $display("FAIL coll_b_write_first got %b/%h expected 1/3333", rv_w[1][1], rd_w[1][1]); end
        a_en = 1'b1; a_we = 1'b1; a_be = 2'b01; a_addr = 8'h21; a_wdata = 16'h00AA;
        b_en = 1'b1; b_we = 1'b1; b_be = 2'b10; b_addr = 8'h21; b_wdata = 16'hBB00;
        $display("txn collision: A write 21=00aa be=01, B write 21=bb00 be=10");
        tick();
        idle();
        n_cmp++;
        if (rd_w[0][0] !== 16'h2211) begin n_fail++; $display("FAIL coll_rw_old_lat2 got %h expected 2211", rd_w[0][0]); end
        n_cmp++;
        if (coll_w[2] !== 1'b1) begin n_fail++; $display("FAIL coll_disjoint_be got %b expected 1", coll_w[2]); end
        a_en = 1'b1; a_addr = 8'h21;
        $display("txn collision: A read addr=21");
        tick();
        idle();
        n_cmp++;
        if (rd_w[2][0] !== 16'hBBAA) begin n_fail++; $display("FAIL coll_disjoint_data got %h expected bbaa", rd_w[2][0]); end
        tick();
    endtask

    task automatic test_reset_inflight();
        int rise = -1;
        bit got  = 1'b0;
        a_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_addr = 8'(5 + i);
            $display("txn inflight: A read addr=%h", a_addr);
            tick();
            if (i == 1) begin
                n_cmp++;
                if (rv_w[0][0] !== 1'b1 || rd_w[0][0] !== 16'hBEEF) begin n_fail++; $display("FAIL inflight_pre got %b/%h expected 1/beef", rv_w[0][0], rd_w[0][0]); end
            end
        end
        rst = 1'b1; a_addr = 8'h05;
        $display("txn inflight: rst asserted");
        tick();
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (ready_w[d] !== 1'b0) begin n_fail++; $display("FAIL inflight_ready dut%0d got %b expected 0", d, ready_w[d]); end
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (rv_w[d][p] !== 1'b0) begin n_fail++; $display("FAIL inflight_drop dut%0d port%0d got %b expected 0", d, p, rv_w[d][p]); end
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 100; c++) tick();
        rst = 1'b1;
        $display("txn inflight: rst asserted mid-init");
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 262; c++) begin
            tick();
            if (rise < 0 && ready_w[0] === 1'b1) rise = c;
            n_cmp++;
            if (rv_w[0][0] !== exp_v[0][0] || ready_w[1] !== ready_m) begin
                n_fail++;
                $display("FAIL reinit_state c=%0d got rvalid=%b ready=%b expected %b/%b", c, rv_w[0][0], ready_w[1], exp_v[0][0], ready_m);
            end
            if (!got && rv_w[1][0] === 1'b1) begin
                got = 1'b1;
                n_cmp++;
                if (rd_w[1][0] !== 16'h0000) begin n_fail++; $display("FAIL reinit_zeroed got %h expected 0000", rd_w[1][0]); end
            end
        end
        $display("txn inflight: ready rose again after cycle %0d", rise);
        n_cmp++;
        if (rise != 257) begin n_fail++; $display("FAIL reinit_ready_cycle got %0d expected 257", rise); end
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL reinit_read got no rvalid expected one"); end
        idle();
        tick();
        tick();
    endtask

    task automatic test_random_stream();
        for (int c = 0; c < 512; c++) begin
            a_en = 1'b1; b_en = 1'b1;
            a_we = (c % 2 == 0); b_we = (c % 2 == 0);
            a_addr = 8'($urandom_range(0, 127));
            b_addr = 8'($urandom_range(128, 255));
            a_be = 2'($urandom); b_be = 2'($urandom);
            a_wdata = 16'($urandom); b_wdata = 16'($urandom);
            $display("txn stream %0d: we=%b A addr=%h data=%h be=%b B addr=%h data=%h be=%b",
                     c, a_we, a_addr, a_wdata, a_be, b_addr, b_wdata, b_be);
            tick();
            for (int d = 0; d < NDUT; d++) begin
                for (int p = 0; p < 2; p++) begin
                    n_cmp++;
                    if (rv_w[d][p] !== exp_v[d][p] || rd_w[d][p] !== exp_d[d][p]) begin
                        n_fail++;
                        $display("FAIL stream_read c=%0d dut%0d port%0d got %b/%h expected %b/%h", c, d, p, rv_w[d][p], rd_w[d][p], exp_v[d][p], exp_d[d][p]);
                    end
                end
                n_cmp++;
                if (coll_w[d] !== 1'b0) begin n_fail++; $display("FAIL stream_collision c=%0d dut%0d got %b expected 0", c, d, coll_w[d]); end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_init();
        test_cross_port();
        test_rw_mode();
        test_collision();
        test_reset_inflight();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
